// File: rtl/comp_pkg.sv
// Shared definitions for the streaming comparator: one-hot result encoding and the
// reference compare function used by comp_core.
package comp_pkg;

  typedef logic [2:0] res_t;

  localparam res_t RES_AG = 3'b100;
  localparam res_t RES_EQ = 3'b010;
  localparam res_t RES_BG = 3'b001;

  // Operands are widened to MAX_W bits by the caller, so SIZE must stay below MAX_W.
  localparam int MAX_W = 64;

  // a and b must already be sign- or zero-extended to match is_signed.
  function automatic res_t cmp_onehot(input logic [MAX_W-1:0] a,
                                      input logic [MAX_W-1:0] b,
                                      input logic             is_signed);
    logic lt;
    if (a == b) return RES_EQ;
    lt = is_signed ? ($signed(a) < $signed(b)) : (a < b);
    return lt ? RES_BG : RES_AG;
  endfunction

endpackage

// File: rtl/comp_core.sv
// Combinational compare of A against B: one-hot ag/eq/bg result plus the
// overflow-free SIZE+1-bit difference B - A used for release hysteresis.
module comp_core
  import comp_pkg::*;
#(
  parameter int SIZE   = 16,
  parameter int SIGNED = 0
) (
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  output res_t            res,
  output logic [SIZE:0]   diff
);

  localparam logic SGN = (SIGNED != 0);

  logic             ext_a;
  logic             ext_b;
  logic [MAX_W-1:0] a_w;
  logic [MAX_W-1:0] b_w;

  assign ext_a = SGN & A[SIZE-1];
  assign ext_b = SGN & B[SIZE-1];

  assign a_w = {{(MAX_W-SIZE){ext_a}}, A};
  assign b_w = {{(MAX_W-SIZE){ext_b}}, B};

  assign res  = cmp_onehot(a_w, b_w, SGN);
  assign diff = {ext_b, B} - {ext_a, A};

endmodule

// File: rtl/comp_stream.sv
// Registered streaming comparator with valid/ready handshake, saturating A>B run
// counter and sticky trip flag. Define COMP_HYST_EN to require B - A > HYST for release.
module comp_stream
  import comp_pkg::*;
#(
  parameter int SIZE    = 16,
  parameter int SIGNED  = 0,
  parameter int CW      = 8,
  parameter int RUN_LEN = 4,
  parameter int HYST    = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            ag,
  output logic            eq,
  output logic            bg,
  output logic [CW-1:0]   run_cnt,
  output logic            trip
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] RUN_TGT = CW'(RUN_LEN);

  res_t          core_res;
  logic [SIZE:0] diff;
  res_t          res_q;
  logic          accept;
  logic          is_ag;
  logic          release_ok;
  logic [CW-1:0] cnt_inc;

  comp_core #(
    .SIZE   (SIZE),
    .SIGNED (SIGNED)
  ) u_core (
    .A    (A),
    .B    (B),
    .res  (core_res),
    .diff (diff)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_ag    = (core_res == RES_AG);
  assign cnt_inc  = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + 1'b1;

`ifdef COMP_HYST_EN
  localparam int DW = SIZE + 1;
  localparam logic signed [SIZE:0] HYST_W = DW'(HYST);

  // Only a clear undershoot of the limit releases trip; near-misses keep it latched.
  assign release_ok = (core_res == RES_BG) && ($signed(diff) > HYST_W);
`else
  logic unused_hyst;

  assign unused_hyst = ^{diff, HYST};
  assign release_ok  = !is_ag;
`endif

  // NOTE: the result register is reset too, not just out_valid, because ag/eq/bg
  // must read 0 after reset rather than whatever the last beat left behind.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid <= 1'b0;
      res_q     <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      out_valid <= 1'b1;
      res_q     <= core_res;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign ag = |(res_q & RES_AG);
  assign eq = |(res_q & RES_EQ);
  assign bg = |(res_q & RES_BG);

  // clr wins over a same-cycle accept: the beat still delivers its result but is not counted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      run_cnt <= '0;
      trip    <= 1'b0;
    end else if (clr) begin
      run_cnt <= '0;
      trip    <= 1'b0;
    end else if (accept) begin
      if (is_ag) begin
        run_cnt <= cnt_inc;
        if (cnt_inc == RUN_TGT) trip <= 1'b1;
      end else begin
        run_cnt <= '0;
        if (release_ok) trip <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_comp_stream.sv
// Scoreboard bench for comp_stream: unsigned, signed and narrow-counter instances share
// stimulus; an accept monitor pushes model results that each beat pops and compares.
module tb_comp_stream;

  logic        CLK;
  logic        RST;
  logic [15:0] A;
  logic [15:0] B;
  logic        in_valid;
  logic        clr;
  logic        out_ready;

  logic       in_ready_u, out_valid_u, ag_u, eq_u, bg_u, trip_u;
  logic [7:0] run_cnt_u;
  logic       in_ready_s, out_valid_s, ag_s, eq_s, bg_s, trip_s;
  logic [7:0] run_cnt_s;
  logic       in_ready_c, out_valid_c, ag_c, eq_c, bg_c, trip_c;
  logic [2:0] run_cnt_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] res_u, res_s, res_c;
    int         cnt_u, cnt_s, cnt_c;
    bit         trip_u, trip_s, trip_c;
  } exp_t;

  exp_t sb[$];
  int   m_cnt_u = 0, m_cnt_s = 0, m_cnt_c = 0;
  bit   m_trip_u = 0, m_trip_s = 0, m_trip_c = 0;

  comp_stream #(.SIGNED(0)) dut_u (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready_u),
    .clr(clr), .out_valid(out_valid_u), .out_ready(out_ready), .ag(ag_u), .eq(eq_u),
    .bg(bg_u), .run_cnt(run_cnt_u), .trip(trip_u)
  );

  comp_stream #(.SIGNED(1)) dut_s (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready_s),
    .clr(clr), .out_valid(out_valid_s), .out_ready(out_ready), .ag(ag_s), .eq(eq_s),
    .bg(bg_s), .run_cnt(run_cnt_s), .trip(trip_s)
  );

  comp_stream #(.SIGNED(0), .CW(3), .RUN_LEN(4)) dut_c (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready_c),
    .clr(clr), .out_valid(out_valid_c), .out_ready(out_ready), .ag(ag_c), .eq(eq_c),
    .bg(bg_c), .run_cnt(run_cnt_c), .trip(trip_c)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [2:0] ref_cmp(input logic [15:0] a, input logic [15:0] b,
                                         input bit sgn);
    int ai, bi;
    ai = sgn ? int'($signed(a)) : int'(a);
    bi = sgn ? int'($signed(b)) : int'(b);
    if (ai > bi) return 3'b100;
    if (ai == bi) return 3'b010;
    return 3'b001;
  endfunction

  task automatic model_step(input logic [2:0] res, input int diff, input logic c,
                            input int maxv, inout int cnt, inout bit trip);
    bit rel;
    if (c) begin
      cnt  = 0;
      trip = 0;
    end else if (res == 3'b100) begin
      if (cnt < maxv) cnt++;
      if (cnt == 4) trip = 1;
    end else begin
      cnt = 0;
`ifdef COMP_HYST_EN
      rel = (res == 3'b001) && (diff > 2);
`else
      rel = 1;
`endif
      if (rel) trip = 0;
    end
  endtask

  // Accept monitor: builds the expected result of every beat the DUT takes.
  always @(posedge CLK) begin
    exp_t e;
    if (RST === 1'b1 && in_valid === 1'b1 && in_ready_u === 1'b1) begin
      e.res_u = ref_cmp(A, B, 0);
      e.res_s = ref_cmp(A, B, 1);
      e.res_c = e.res_u;
      model_step(e.res_u, int'(B) - int'(A), clr, 255, m_cnt_u, m_trip_u);
      model_step(e.res_s, int'($signed(B)) - int'($signed(A)), clr, 255, m_cnt_s, m_trip_s);
      model_step(e.res_c, int'(B) - int'(A), clr, 7, m_cnt_c, m_trip_c);
      e.cnt_u = m_cnt_u;  e.trip_u = m_trip_u;
      e.cnt_s = m_cnt_s;  e.trip_s = m_trip_s;
      e.cnt_c = m_cnt_c;  e.trip_c = m_trip_c;
      sb.push_back(e);
    end
  end

  // Drive one beat, wait (bounded) for acceptance, then pop and compare its result.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                      output int waited);
    bit   acc;
    exp_t e;
    A = a; B = b; clr = c; in_valid = 1'b1;
    waited = 0;
    acc = 0;
    while (!acc && waited < 20) begin
      acc = in_ready_u;
      @(posedge CLK); #1;
      waited++;
    end
    in_valid = 1'b0;
    clr = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: beat A=%h B=%h not accepted within 20 cycles", a, b);
      return;
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: beat A=%h B=%h accepted but not recorded", a, b);
      return;
    end
    e = sb.pop_front();
    checks++;
    if ({out_valid_u, out_valid_s, out_valid_c} !== 3'b111) begin
      errors++;
      $display("FAIL out_valid: got %b required 111 (A=%h B=%h)",
               {out_valid_u, out_valid_s, out_valid_c}, a, b);
    end
    checks++;
    if ({ag_u, eq_u, bg_u} !== e.res_u || run_cnt_u !== 8'(e.cnt_u) || trip_u !== e.trip_u) begin
      errors++;
      $display("FAIL beat_u A=%h B=%h: got res=%b cnt=%0d trip=%b required res=%b cnt=%0d trip=%b",
               a, b, {ag_u, eq_u, bg_u}, run_cnt_u, trip_u, e.res_u, e.cnt_u, e.trip_u);
    end
    checks++;
    if ({ag_s, eq_s, bg_s} !== e.res_s || run_cnt_s !== 8'(e.cnt_s) || trip_s !== e.trip_s) begin
      errors++;
      $display("FAIL beat_s A=%h B=%h: got res=%b cnt=%0d trip=%b required res=%b cnt=%0d trip=%b",
               a, b, {ag_s, eq_s, bg_s}, run_cnt_s, trip_s, e.res_s, e.cnt_s, e.trip_s);
    end
    checks++;
    if ({ag_c, eq_c, bg_c} !== e.res_c || run_cnt_c !== 3'(e.cnt_c) || trip_c !== e.trip_c) begin
      errors++;
      $display("FAIL beat_c A=%h B=%h: got res=%b cnt=%0d trip=%b required res=%b cnt=%0d trip=%b",
               a, b, {ag_c, eq_c, bg_c}, run_cnt_c, trip_c, e.res_c, e.cnt_c, e.trip_c);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; A = 16'd5; B = 16'd3; in_valid = 1'b1; clr = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({out_valid_u, ag_u, eq_u, bg_u, trip_u} !== 5'b0 || run_cnt_u !== 8'd0) begin
      errors++;
      $display("FAIL reset_u: got vld/ag/eq/bg/trip=%b cnt=%0d required all 0",
               {out_valid_u, ag_u, eq_u, bg_u, trip_u}, run_cnt_u);
    end
    checks++;
    if ({out_valid_s, ag_s, eq_s, bg_s, trip_s} !== 5'b0 || run_cnt_s !== 8'd0) begin
      errors++;
      $display("FAIL reset_s: got vld/ag/eq/bg/trip=%b cnt=%0d required all 0",
               {out_valid_s, ag_s, eq_s, bg_s, trip_s}, run_cnt_s);
    end
    checks++;
    if ({out_valid_c, ag_c, eq_c, bg_c, trip_c} !== 5'b0 || run_cnt_c !== 3'd0) begin
      errors++;
      $display("FAIL reset_c: got vld/ag/eq/bg/trip=%b cnt=%0d required all 0",
               {out_valid_c, ag_c, eq_c, bg_c, trip_c}, run_cnt_c);
    end
    in_valid = 1'b0;
    #3 RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (out_valid_u !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: out_valid=%b required 0", out_valid_u);
    end
  endtask

  task automatic test_basic();
    int w;
    send(16'd5, 16'd3, 1'b0, w);
    checks++;
    if (ag_u !== 1'b1 || w != 1) begin
      errors++;
      $display("FAIL basic_latency: ag=%b cycles=%0d required ag=1 cycles=1", ag_u, w);
    end
    send(16'd3, 16'd3, 1'b0, w);
    checks++;
    if (eq_u !== 1'b1) begin
      errors++;
      $display("FAIL basic_eq: eq=%b required 1", eq_u);
    end
    send(16'd2, 16'd9, 1'b0, w);
    checks++;
    if (bg_u !== 1'b1) begin
      errors++;
      $display("FAIL basic_bg: bg=%b required 1", bg_u);
    end
  endtask

  task automatic test_signed();
    int w;
    send(16'hFFFF, 16'h0001, 1'b0, w);
    checks++;
    if (bg_s !== 1'b1 || ag_u !== 1'b1) begin
      errors++;
      $display("FAIL signed_ffff: bg_s=%b ag_u=%b required 1 1", bg_s, ag_u);
    end
    send(16'h8000, 16'h7FFF, 1'b0, w);
    checks++;
    if (bg_s !== 1'b1 || ag_u !== 1'b1) begin
      errors++;
      $display("FAIL signed_min: bg_s=%b ag_u=%b required 1 1", bg_s, ag_u);
    end
    send(16'h7FFF, 16'h8000, 1'b0, w);
    checks++;
    if (ag_s !== 1'b1 || bg_u !== 1'b1) begin
      errors++;
      $display("FAIL signed_max: ag_s=%b bg_u=%b required 1 1", ag_s, bg_u);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [15:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = (i % 3 == 0) ? a : 16'($urandom_range(0, 65535));
      send(a, b, 1'b0, w);
      checks++;
      if (w != 1) begin
        errors++;
        $display("FAIL back_to_back beat %0d: took %0d cycles required 1", i, w);
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (out_valid_u !== 1'b0) begin
      errors++;
      $display("FAIL drain: out_valid=%b required 0", out_valid_u);
    end
    out_ready = 1'b0;
    send(16'd10, 16'd20, 1'b0, w);
    A = 16'd40; B = 16'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready_u !== 1'b0) begin
        errors++;
        $display("FAIL hold_ready cycle %0d: in_ready=%b required 0", i, in_ready_u);
      end
      @(posedge CLK); #1;
      checks++;
      if ({out_valid_u, ag_u, eq_u, bg_u} !== 4'b1001) begin
        errors++;
        $display("FAIL hold_frozen cycle %0d: vld/ag/eq/bg=%b required 1001",
                 i, {out_valid_u, ag_u, eq_u, bg_u});
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready_u !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: in_ready=%b required 1", in_ready_u);
    end
    send(16'd40, 16'd1, 1'b0, w);
    checks++;
    if (w != 1 || ag_u !== 1'b1) begin
      errors++;
      $display("FAIL release_accept: cycles=%0d ag=%b required 1 1", w, ag_u);
    end
  endtask

  task automatic test_trip();
    int w;
    send(16'd3, 16'd3, 1'b1, w);
    for (int i = 1; i <= 4; i++) begin
      send(16'd20, 16'd10, 1'b0, w);
      checks++;
      if (run_cnt_u !== 8'(i) || trip_u !== (i == 4)) begin
        errors++;
        $display("FAIL trip_run beat %0d: cnt=%0d trip=%b required cnt=%0d trip=%b",
                 i, run_cnt_u, trip_u, i, (i == 4));
      end
    end
    send(16'd10, 16'd10, 1'b0, w);
    checks++;
`ifdef COMP_HYST_EN
    if (run_cnt_u !== 8'd0 || trip_u !== 1'b1) begin
      errors++;
      $display("FAIL trip_eq: cnt=%0d trip=%b required 0 1", run_cnt_u, trip_u);
    end
    send(16'd9, 16'd10, 1'b0, w);
    checks++;
    if (trip_u !== 1'b1) begin
      errors++;
      $display("FAIL trip_near_miss: trip=%b required 1", trip_u);
    end
`else
    if (run_cnt_u !== 8'd0 || trip_u !== 1'b0) begin
      errors++;
      $display("FAIL trip_eq: cnt=%0d trip=%b required 0 0", run_cnt_u, trip_u);
    end
`endif
    send(16'd7, 16'd10, 1'b0, w);
    checks++;
    if (trip_u !== 1'b0) begin
      errors++;
      $display("FAIL trip_release: trip=%b required 0", trip_u);
    end
  endtask

  task automatic test_sat_clr();
    int w;
    send(16'd1, 16'd1, 1'b1, w);
    for (int i = 0; i < 9; i++) send(16'd30, 16'd2, 1'b0, w);
    checks++;
    if (run_cnt_c !== 3'd7 || trip_c !== 1'b1 || run_cnt_u !== 8'd9) begin
      errors++;
      $display("FAIL saturate: cnt_c=%0d trip_c=%b cnt_u=%0d required 7 1 9",
               run_cnt_c, trip_c, run_cnt_u);
    end
    send(16'd30, 16'd2, 1'b1, w);
    checks++;
    if (run_cnt_c !== 3'd0 || trip_c !== 1'b0 || ag_c !== 1'b1 || run_cnt_u !== 8'd0) begin
      errors++;
      $display("FAIL clr_accept: cnt_c=%0d trip_c=%b ag_c=%b cnt_u=%0d required 0 0 1 0",
               run_cnt_c, trip_c, ag_c, run_cnt_u);
    end
  endtask

  task automatic test_async_reset();
    int w;
    for (int i = 0; i < 4; i++) send(16'd100, 16'd5, 1'b0, w);
    checks++;
    if (trip_u !== 1'b1 || out_valid_u !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: trip=%b out_valid=%b required 1 1", trip_u, out_valid_u);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({out_valid_u, ag_u, eq_u, bg_u, trip_u, out_valid_s, trip_s, out_valid_c, trip_c} !== 9'b0
        || run_cnt_u !== 8'd0 || run_cnt_s !== 8'd0 || run_cnt_c !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: vld/ag/eq/bg/trip=%b cnt_u=%0d required all 0",
               {out_valid_u, ag_u, eq_u, bg_u, trip_u}, run_cnt_u);
    end
    sb.delete();
    m_cnt_u = 0; m_cnt_s = 0; m_cnt_c = 0;
    m_trip_u = 0; m_trip_s = 0; m_trip_c = 0;
    #2 RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (out_valid_u !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: out_valid=%b required 0", out_valid_u);
    end
    send(16'd5, 16'd3, 1'b0, w);
    checks++;
    if (run_cnt_u !== 8'd1 || trip_u !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_run: cnt=%0d trip=%b required 1 0", run_cnt_u, trip_u);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_trip();
    test_sat_clr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp_stream.md
Name: comp_stream

Overview:
- Streaming, registered successor to the basic comparator, used by the IIR filter datapath for overflow and limit detection.
- Compares sample A against limit B each accepted beat, with signed or unsigned interpretation set by a parameter.
- Registers the ag/eq/bg result behind a valid/ready handshake.
- Tracks consecutive A>B beats in a saturating run counter and raises a sticky trip flag after RUN_LEN consecutive exceedances.

Parameters:
- SIZE, 16, bit width of A and B.
- SIGNED, 0, 1 = two's-complement compare; 0 = unsigned compare.
- CW, 8, run-counter width.
- RUN_LEN, 4, consecutive A>B beats that set trip; legal range 1..2^CW-1.
- HYST, 2, release margin in LSBs; used only when COMP_HYST_EN is defined.

Ports:
- CLK, input, 1, rising-edge clock.
- RST, input, 1, asynchronous active-low reset.
- A, input, SIZE, sample operand.
- B, input, SIZE, limit operand.
- in_valid, input, 1, A/B valid.
- in_ready, output, 1, block can accept A/B.
- clr, input, 1, synchronous clear of run_cnt and trip.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts result.
- ag, output, 1, A>B.
- eq, output, 1, A==B.
- bg, output, 1, A<B.
- run_cnt, output, CW, current consecutive A>B count.
- trip, output, 1, sticky exceedance flag.

Behaviour:
- Reset: RST low clears out_valid, ag, eq, bg, run_cnt and trip to 0 immediately, independent of CLK. This applies mid-transfer too: a pending result is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Latency: a beat accepted at edge N presents its result with out_valid=1 after edge N.
- Throughput: 1 beat/cycle while out_ready stays high.
- Holding: while out_valid && !out_ready, ag/eq/bg stay frozen and no new beat is accepted.
- out_valid:
  - Set on accept.
  - Cleared on output transfer when no beat is accepted in the same cycle.
  - Transfer and accept in the same cycle: stays 1 and loads the new result.
- Result encoding: exactly one of ag/eq/bg is 1 whenever out_valid=1. All three are 0 after reset, until the first result loads.
- Compare rules:
  - SIGNED=1: operands compared as two's complement, e.g. SIZE=4, A=4'b1000 (-8) < B=4'b0001.
  - SIGNED=0: operands compared unsigned.
- Run counter, updated on accept (same edge the result loads):
  - Result ag: run_cnt increments, saturating at 2^CW-1 with no wrap.
  - Result eq or bg: run_cnt returns to 0.
- Trip set: trip goes to 1 on the accept edge where the new run_cnt value equals RUN_LEN, or on any accept with ag while trip is already 1 (it stays 1).
- Trip release (macro absent): trip clears on the first accepted beat with result eq or bg.
- clr: on an edge with clr=1, run_cnt and trip go to 0.
  - clr has priority over a same-cycle accept: that beat's ag/eq/bg still load and transfer normally, but the beat is not counted.
  - clr has no effect on out_valid or on ag/eq/bg.
- Handshake is unaffected by trip; trip is status only.

Optional Feature:
- Macro: COMP_HYST_EN.
- Defined: trip release requires an accepted beat with B - A > HYST.
  - Evaluate in SIZE+1 bits with sign extension per SIGNED, so there is no overflow.
  - A beat with bg but B - A <= HYST resets run_cnt and leaves trip at 1.
  - eq beats also leave trip unchanged.
- Absent: release on first eq/bg beat, as described under Behaviour; the HYST parameter is unused.

Decomposition:
- Shared package comp_pkg holds:
  - the result-encoding localparams (RES_AG, RES_EQ, RES_BG as a 3-bit one-hot);
  - a function returning the one-hot result for given operands and signedness.
- One sub-module, comp_core: purely combinational, parameters SIZE and SIGNED, inputs A/B, one-hot result plus the SIZE+1-bit difference B - A for the hysteresis check.
- comp_stream owns the handshake register, run counter and trip logic.

Test Plan:
- Reset and basic compare:
  - Hold RST low with in_valid=1 -> out_valid=0, ag=eq=bg=0, run_cnt=0, trip=0.
  - Release, send SIZE=16 unsigned A=5,B=3 -> one cycle later out_valid=1, ag=1.
- Signedness: SIGNED=1, A=16'hFFFF, B=1 -> bg=1; same vectors with SIGNED=0 -> ag=1.
- Backpressure: out_ready=0 with a result pending, change A/B -> in_ready=0 and ag/eq/bg frozen. Raise out_ready -> next beat accepted same cycle, out_valid stays 1.
- Trip, RUN_LEN=4: four accepted A>B beats -> run_cnt 1,2,3,4 and trip=1 on the 4th. Then A=B -> run_cnt=0; trip clears (macro absent) or stays 1 (COMP_HYST_EN, HYST=2).
  - With COMP_HYST_EN, A=7,B=10 -> trip clears.
- Saturation and clr, CW=3, RUN_LEN=4:
  - Nine A>B beats -> run_cnt saturates at 7.
  - clr together with an A>B accept -> run_cnt=0, trip=0, ag=1 still delivered.
- Async reset mid-stream: assert RST between clock edges while out_valid=1 and trip=1 -> all outputs 0 before the next edge.
